addx_copro_unit: RTL and testbench

ADDX_COPRO_UNIT -- requirements
Module: addx_copro_unit

---
 rtl/addx_copro_pkg.sv | 27 ++
 rtl/addx_copro_if.sv | 46 ++++
 rtl/addx_result_fifo.sv | 72 +++++++
 rtl/addx_copro_unit.sv | 112 +++++++++++
 tb/tb_addx_copro_unit.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/addx_copro_pkg.sv
// addx_copro_pkg
// Shared definitions for the ADDX coprocessor slice:
//   - ADDX opcode / funct3 encodings
//   - addx_res_t : result buffer entry (id, rd, data) at the default widths
//   - is_addx()  : combinational decode of an offloaded instruction word
// The unit is only instantiated by its parent when the core build has
// CvxifEn=1 and EnableADDX=1; nothing in this slice depends on those flags.
package addx_copro_pkg;

  localparam logic [6:0] ADDX_OPCODE = 7'b0001011;
  localparam logic [2:0] ADDX_FUNCT3 = 3'b000;

  // Result entry at the default configuration (IdWidth=4, XLEN=64).
  typedef struct packed {
    logic [3:0]  id;
    logic [4:0]  rd;
    logic [63:0] data;
  } addx_res_t;

  // All three fields must match; funct7[1:0] is the shift amount and is free.
  function automatic logic is_addx(input logic [31:0] instr);
    return (instr[6:0] == ADDX_OPCODE) &&
           (instr[14:12] == ADDX_FUNCT3) &&
           (instr[31:27] == 5'b00000);
  endfunction

endpackage

// File: rtl/addx_copro_if.sv
// addx_copro_if
// Offload bus between the core (master) and the ADDX unit (slave).
//   issue_*  : request channel, core -> unit
//   flush_i  : drop all in-flight and buffered work
//   result_* : result channel, unit -> core
//
// Handshake semantics (both channels): a transfer happens on a rising edge
// where valid and ready are both 1. Once valid is raised the sender holds
// valid and its payload stable until the transfer. ready may depend on
// valid's channel state but never on the payload. issue_accept_o is only
// meaningful while issue_valid_i=1; a transfer with accept=0 consumes the
// request without producing a result.
interface addx_copro_if #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned IdWidth = 4
) ();

  logic               issue_valid_i;
  logic               issue_ready_o;
  logic [31:0]        issue_instr_i;
  logic [IdWidth-1:0] issue_id_i;
  logic [XLEN-1:0]    issue_rs1_i;
  logic [XLEN-1:0]    issue_rs2_i;
  logic               issue_accept_o;
  logic               flush_i;
  logic               result_valid_o;
  logic               result_ready_i;
  logic [IdWidth-1:0] result_id_o;
  logic [4:0]         result_rd_o;
  logic [XLEN-1:0]    result_data_o;

  modport master (
    output issue_valid_i, issue_instr_i, issue_id_i, issue_rs1_i, issue_rs2_i,
    output flush_i, result_ready_i,
    input  issue_ready_o, issue_accept_o,
    input  result_valid_o, result_id_o, result_rd_o, result_data_o
  );

  modport slave (
    input  issue_valid_i, issue_instr_i, issue_id_i, issue_rs1_i, issue_rs2_i,
    input  flush_i, result_ready_i,
    output issue_ready_o, issue_accept_o,
    output result_valid_o, result_id_o, result_rd_o, result_data_o
  );

endinterface

// File: rtl/addx_result_fifo.sv
// addx_result_fifo
// Small parameterised FIFO holding finished results.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   flush_i       : empties the FIFO at the end of the cycle
//   push_i/data_i : write an entry
//   pop_i         : remove the head entry (caller never pops when empty)
//   data_o        : head entry (undefined when empty; storage is not reset)
//   empty_o       : no entries held
//   count_o       : number of entries held
// Pointers wrap modulo Depth; full and empty are told apart by count.
module addx_result_fifo
  import addx_copro_pkg::*;
#(
  parameter int unsigned Depth = 2,
  parameter type         T     = addx_res_t
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  T                           data_i,
  input  logic                       pop_i,
  output T                           data_o,
  output logic                       empty_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);

  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  T                mem [Depth];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic [CntW-1:0] count;
  logic            full;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full    = (count == CntW'(Depth));
  assign empty_o = (count == '0);
  assign count_o = count;
  assign data_o  = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem[wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_i) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_i)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CntW'(push_i) - CntW'(pop_i);
    end
  end

  // Push on a full buffer is only legal together with a pop.
  always_ff @(posedge clk_i) begin
    if (rst_ni && !flush_i) begin
      no_overflow:  assert (!(push_i && full && !pop_i));
      no_underflow: assert (!(pop_i && empty_o));
    end
  end

endmodule

// File: rtl/addx_copro_unit.sv
// addx_copro_unit
// ADDX offload unit: result = rs1 + (rs2 << funct7[1:0]), XLEN bits, carries
// dropped. One compute stage (S1) feeding an in-order result buffer, so the
// first result is visible two cycles after its issue handshake.
//   clk_i, rst_ni  : clock, synchronous active-low reset
//   bus            : offload bus (issue / flush / result), slave side
//   accepted_cnt_o : running count of accepted ADDX instructions (wraps)
// issue_ready_o is a credit check on S1 + buffer occupancy, so S1 never has
// to stall and the buffer can never overflow.
module addx_copro_unit
  import addx_copro_pkg::*;
#(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned IdWidth  = 4,
  parameter int unsigned ResDepth = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  addx_copro_if.slave bus,
  output logic [31:0] accepted_cnt_o
);

  localparam int unsigned CntW = $clog2(ResDepth + 1);

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [4:0]         rd;
    logic [XLEN-1:0]    data;
  } res_entry_t;

  logic               s1_valid;
  logic [XLEN-1:0]    s1_rs1;
  logic [XLEN-1:0]    s1_rs2;
  logic [1:0]         s1_sh;
  logic [4:0]         s1_rd;
  logic [IdWidth-1:0] s1_id;

  logic [CntW-1:0]    buf_count;
  logic               buf_empty;
  logic               buf_pop;
  res_entry_t         push_entry;
  res_entry_t         head_entry;

  logic [CntW:0]      occupancy;
  logic               issue_hs;
  logic               issue_take;
  logic [31:0]        accepted_cnt_q;

  // Issue side
  assign bus.issue_accept_o = is_addx(bus.issue_instr_i);
  assign occupancy          = (CntW+1)'(buf_count) + (CntW+1)'(s1_valid);
  assign bus.issue_ready_o  = (occupancy < (CntW+1)'(ResDepth)) && !bus.flush_i;
  assign issue_hs           = bus.issue_valid_i && bus.issue_ready_o;
  assign issue_take         = issue_hs && bus.issue_accept_o;

  // S1: operand capture; the adder sits between S1 and the buffer.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || bus.flush_i) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= issue_take;
    end
  end

  always_ff @(posedge clk_i) begin
    if (issue_take) begin
      s1_rs1 <= bus.issue_rs1_i;
      s1_rs2 <= bus.issue_rs2_i;
      s1_sh  <= bus.issue_instr_i[26:25];
      s1_rd  <= bus.issue_instr_i[11:7];
      s1_id  <= bus.issue_id_i;
    end
  end

  assign push_entry = '{id: s1_id, rd: s1_rd, data: s1_rs1 + (s1_rs2 << s1_sh)};

  // Result buffer
  assign buf_pop = bus.result_ready_i && !buf_empty;

  addx_result_fifo #(
    .Depth (ResDepth),
    .T     (res_entry_t)
  ) u_result_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (bus.flush_i),
    .push_i  (s1_valid),
    .data_i  (push_entry),
    .pop_i   (buf_pop),
    .data_o  (head_entry),
    .empty_o (buf_empty),
    .count_o (buf_count)
  );

  // Storage is not reset, so the result fields are masked while empty.
  assign bus.result_valid_o = !buf_empty;
  assign bus.result_id_o    = buf_empty ? '0 : head_entry.id;
  assign bus.result_rd_o    = buf_empty ? '0 : head_entry.rd;
  assign bus.result_data_o  = buf_empty ? '0 : head_entry.data;

  // Accepted-instruction counter survives flush; only reset clears it.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      accepted_cnt_q <= '0;
    end else if (issue_take) begin
      accepted_cnt_q <= accepted_cnt_q + 32'd1;
    end
  end

  assign accepted_cnt_o = accepted_cnt_q;

endmodule

// File: tb/tb_addx_copro_unit.sv
// tb_addx_copro_unit
// Bench for addx_copro_unit: directed scenarios plus randomized traffic,
// all checked against a queue-based model of outstanding results.
module tb_addx_copro_unit;

  localparam int XLEN  = 64;
  localparam int IDW   = 4;
  localparam int DEPTH = 2;

  // Clock / reset
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] cnt;

  always #5 clk = ~clk;

  addx_copro_if #(.XLEN(XLEN), .IdWidth(IDW)) bus ();

  addx_copro_unit #(
    .XLEN     (XLEN),
    .IdWidth  (IDW),
    .ResDepth (DEPTH)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .bus            (bus.slave),
    .accepted_cnt_o (cnt)
  );

  // Scoreboard: expected results {id, rd, data} in issue order, with the
  // number of cycles each has existed since its issue handshake.
  int          n_vec = 0;
  int          n_err = 0;
  logic [72:0] exp_q[$];
  int          age_q[$];
  logic [31:0] cnt_m = 32'd0;

  task automatic chk(input string tag, input logic [72:0] obs, input logic [72:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] addx_word(input logic [1:0] sh, input logic [4:0] rd);
    return {5'b00000, sh, 5'd2, 5'd1, 3'b000, rd, 7'b0001011};
  endfunction

  function automatic bit ref_is_addx(input logic [31:0] w);
    return (w & 32'hF800_707F) == 32'h0000_000B;
  endfunction

  // Driver tasks
  task automatic drive(input logic v, input logic [31:0] instr, input logic [IDW-1:0] id,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic rdy, input logic fl);
    bus.issue_valid_i  = v;
    bus.issue_instr_i  = instr;
    bus.issue_id_i     = id;
    bus.issue_rs1_i    = a;
    bus.issue_rs2_i    = b;
    bus.result_ready_i = rdy;
    bus.flush_i        = fl;
  endtask

  // One clock cycle: drive at the falling edge, check the settled outputs
  // against the model, then advance the model across the rising edge.
  task automatic step(input logic v, input logic [31:0] instr, input logic [IDW-1:0] id,
                      input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                      input logic rdy, input logic fl, output bit hs);
    bit          ready_e;
    bit          head_rdy;
    bit          pop;
    logic [72:0] head;
    drive(v, instr, id, a, b, rdy, fl);
    #1;
    ready_e  = (exp_q.size() < DEPTH) && !fl;
    head_rdy = (exp_q.size() > 0) && (age_q[0] >= 2);
    head     = head_rdy ? exp_q[0] : 73'd0;
    chk("issue_ready", {72'd0, bus.issue_ready_o}, {72'd0, ready_e});
    if (v) chk("issue_accept", {72'd0, bus.issue_accept_o}, {72'd0, ref_is_addx(instr)});
    chk("result_valid", {72'd0, bus.result_valid_o}, {72'd0, head_rdy});
    chk("result_id", {69'd0, bus.result_id_o}, {69'd0, head[72:69]});
    chk("result_rd", {68'd0, bus.result_rd_o}, {68'd0, head[68:64]});
    chk("result_data", {9'd0, bus.result_data_o}, {9'd0, head[63:0]});
    chk("accepted_cnt", {41'd0, cnt}, {41'd0, cnt_m});
    hs  = v && ready_e;
    pop = head_rdy && rdy;
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
      age_q.delete();
    end else begin
      if (pop) begin
        void'(exp_q.pop_front());
        void'(age_q.pop_front());
      end
      foreach (age_q[i]) age_q[i]++;
      if (hs && ref_is_addx(instr)) begin
        exp_q.push_back({id, instr[11:7], a + b * (64'd1 << instr[26:25])});
        age_q.push_back(1);
        cnt_m++;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy, input int n);
    bit hs;
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, '0, '0, '0, rdy, 1'b0, hs);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 32'd0, '0, '0, '0, 1'b1, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {72'd0, bus.issue_ready_o}, 73'd1);
    chk("rst_valid", {72'd0, bus.result_valid_o}, 73'd0);
    chk("rst_id", {69'd0, bus.result_id_o}, 73'd0);
    chk("rst_rd", {68'd0, bus.result_rd_o}, 73'd0);
    chk("rst_data", {9'd0, bus.result_data_o}, 73'd0);
    chk("rst_cnt", {41'd0, cnt}, 73'd0);
    exp_q.delete();
    age_q.delete();
    cnt_m = 32'd0;
    rst_n = 1'b1;
  endtask

  // Stimulus
  initial begin
    bit          hs;
    bit          got;
    logic [31:0] c0;
    logic [31:0] w;

    drive(1'b0, 32'd0, '0, '0, '0, 1'b1, 1'b0);
    @(negedge clk);
    do_reset();

    // Basic ADDX, sh=1: 0x10 + (3 << 1) = 0x16, visible two cycles later.
    step(1'b1, addx_word(2'd1, 5'd7), 4'd5, 64'h10, 64'h3, 1'b1, 1'b0, hs);
    idle(1'b1, 1);
    chk("basic_valid", {72'd0, bus.result_valid_o}, 73'd1);
    chk("basic_data", {9'd0, bus.result_data_o}, 73'h16);
    chk("basic_id", {69'd0, bus.result_id_o}, 73'd5);
    chk("basic_rd", {68'd0, bus.result_rd_o}, 73'd7);
    chk("basic_cnt", {41'd0, cnt}, 73'd1);
    idle(1'b1, 1);

    // Carry out of XLEN is discarded.
    step(1'b1, addx_word(2'd0, 5'd3), 4'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1, 1'b0, hs);
    idle(1'b1, 1);
    chk("wrap_valid", {72'd0, bus.result_valid_o}, 73'd1);
    chk("wrap_data", {9'd0, bus.result_data_o}, 73'd0);
    idle(1'b1, 1);

    // Non-ADDX word: consumed, never produces a result, counter unchanged.
    c0 = cnt_m;
    step(1'b1, {7'd0, 5'd5, 5'd6, 3'b000, 5'd3, 7'b0110011}, 4'd2, 64'd5, 64'd6, 1'b1, 1'b0, hs);
    idle(1'b1, 4);
    chk("nonaddx_valid", {72'd0, bus.result_valid_o}, 73'd0);
    chk("nonaddx_cnt", {41'd0, cnt}, {41'd0, c0});

    // Back-pressure: two accepted, third held off until a result drains.
    for (int i = 0; i < 2; i++)
      step(1'b1, addx_word(2'(i), 5'(i + 1)), 4'(i), 64'($urandom()), 64'($urandom()),
           1'b0, 1'b0, hs);
    chk("bp_ready_low", {72'd0, bus.issue_ready_o}, 73'd0);
    step(1'b1, addx_word(2'd2, 5'd3), 4'd2, 64'd100, 64'd7, 1'b0, 1'b0, hs);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step(1'b1, addx_word(2'd2, 5'd3), 4'd2, 64'd100, 64'd7, 1'b1, 1'b0, hs);
      got = hs;
    end
    chk("bp_third_issued", {72'd0, got}, 73'd1);
    idle(1'b1, 6);

    // Flush with two results buffered and a request pending.
    for (int i = 0; i < 2; i++)
      step(1'b1, addx_word(2'd3, 5'd9), 4'(8 + i), 64'($urandom()), 64'($urandom()),
           1'b0, 1'b0, hs);
    idle(1'b0, 2);
    step(1'b1, addx_word(2'd0, 5'd1), 4'd9, 64'd1, 64'd1, 1'b0, 1'b1, hs);
    drive(1'b0, 32'd0, '0, '0, '0, 1'b1, 1'b0);
    #1;
    chk("flush_valid", {72'd0, bus.result_valid_o}, 73'd0);
    chk("flush_ready", {72'd0, bus.issue_ready_o}, 73'd1);
    idle(1'b1, 3);

    // Reset in the middle of work discards it.
    step(1'b1, addx_word(2'd1, 5'd4), 4'd3, 64'd9, 64'd9, 1'b0, 1'b0, hs);
    idle(1'b0, 1);
    do_reset();
    idle(1'b1, 3);

    // Counter wrap: preload to all ones, then one more accept.
    force dut.accepted_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.accepted_cnt_q;
    cnt_m = 32'hFFFF_FFFF;
    chk("cnt_preload", {41'd0, cnt}, {41'd0, 32'hFFFF_FFFF});
    step(1'b1, addx_word(2'd0, 5'd2), 4'd4, 64'd1, 64'd2, 1'b1, 1'b0, hs);
    chk("cnt_wrap", {41'd0, cnt}, 73'd0);
    idle(1'b1, 3);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) != 0) w = addx_word(2'($urandom_range(3)), 5'($urandom_range(31)));
      else w = $urandom();
      step(1'($urandom_range(1)), w, 4'($urandom_range(15)),
           {$urandom(), $urandom()}, {$urandom(), $urandom()},
           1'($urandom_range(4) != 0), 1'($urandom_range(40) == 0), hs);
    end
    idle(1'b1, 6);

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
